// File: rtl/autosym_eval_pipe.sv
// rtl/autosym_eval_pipe.sv - two-stage GF(2) projection + truth-table evaluator with drain-gated config
module autosym_eval_pipe #(
  parameter int N_IN  = 5,
  parameter int K_RED = 4,
  parameter int N_OUT = 1,
  parameter logic [N_OUT-1:0] OUT_INV = '0,
  localparam int TW    = 1 << K_RED,
  localparam int CFG_W = (N_IN > TW) ? N_IN : TW,
  localparam int AMAX  = (K_RED > N_OUT) ? K_RED : N_OUT,
  localparam int AW    = (AMAX <= 1) ? 1 : $clog2(AMAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_y,
  input  logic             cfg_req,
  output logic             cfg_ack,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CFG} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               s1_v;
  logic               s2_v;
  logic [K_RED-1:0]   z;
  logic [K_RED-1:0]   z_nxt;
  logic [N_OUT-1:0]   y_nxt;
  logic [N_IN-1:0]    m   [K_RED];
  logic [TW-1:0]      tbl [N_OUT];
  logic               s1_adv;
  logic               s2_adv;
  logic               accept;
  logic               cfg_wr;

  // Elastic handshake: each stage moves when the stage after it can take its content.
  always_comb begin
    s2_adv   = !s2_v || out_ready;
    s1_adv   = !s1_v || s2_adv;
    in_ready = (state == ST_RUN) && s1_adv;
    accept   = in_valid && in_ready;
    cfg_ack  = (state == ST_CFG) && cfg_req;
    cfg_wr   = cfg_ack && cfg_we;
  end

  // Projection z = M*x over GF(2) and per-channel table lookup.
  always_comb begin
    z_nxt = '0;
    y_nxt = '0;
    for (int r = 0; r < K_RED; r++) begin
      z_nxt[r] = ^(m[r] & in_x);
    end
    for (int o = 0; o < N_OUT; o++) begin
      y_nxt[o] = tbl[o][z] ^ OUT_INV[o];
    end
  end

  // Config FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Config FSM next state: drain the pipeline before opening the window.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (cfg_req) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!cfg_req)          state_nxt = ST_RUN;
        else if (!s1_v && !s2_v) state_nxt = ST_CFG;
      end
      ST_CFG:   if (!cfg_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Stage 1: capture the projected vector of an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      z    <= '0;
    end else begin
      if (s1_adv) s1_v <= accept;
      if (accept) z    <= z_nxt;
    end
  end

  // Stage 2: table result; held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v  <= 1'b0;
      out_y <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) out_y <= y_nxt;
    end
  end

  assign out_valid = s2_v;

  // Matrix rows and truth tables; unmatched addresses fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K_RED; r++) m[r] <= N_IN'(1 << r);
      for (int o = 0; o < N_OUT; o++) tbl[o] <= '0;
    end else if (cfg_wr) begin
      for (int r = 0; r < K_RED; r++) begin
        if (!cfg_sel && cfg_addr == AW'(r)) m[r] <= cfg_wdata[N_IN-1:0];
      end
      for (int o = 0; o < N_OUT; o++) begin
        if (cfg_sel && cfg_addr == AW'(o)) tbl[o] <= cfg_wdata[TW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_autosym_eval_pipe.sv
// tb/tb_autosym_eval_pipe.sv - scoreboard bench for autosym_eval_pipe
module tb_autosym_eval_pipe;
  localparam int N_IN  = 5;
  localparam int K     = 4;
  localparam int N_OUT = 1;
  localparam logic [N_OUT-1:0] INV = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [0:0]  out_y;
  logic        cfg_req = 1'b0;
  logic        cfg_ack;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  mdl_m [K];
  logic [15:0] mdl_t [N_OUT];
  logic [0:0]  exp_q [$];
  logic        prev_stall = 1'b0;
  logic [0:0]  prev_y = '0;

  autosym_eval_pipe #(.N_IN(N_IN), .K_RED(K), .N_OUT(N_OUT), .OUT_INV(INV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  task automatic mdl_reset();
    for (int r = 0; r < K; r++) mdl_m[r] = 5'(1 << r);
    for (int o = 0; o < N_OUT; o++) mdl_t[o] = '0;
  endtask

  function automatic logic [0:0] ref_eval(input logic [4:0] x);
    int z;
    logic [0:0] y;
    z = 0;
    for (int r = 0; r < K; r++)
      if ($countones(mdl_m[r] & x) % 2 == 1) z = z + (1 << r);
    for (int o = 0; o < N_OUT; o++) y[o] = mdl_t[o][z] ^ INV[o];
    return y;
  endfunction

  // Monitor: samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_y", {31'd0, out_y}, {31'd0, prev_y});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_extra: got y=%0h expected no output at %0t", out_y, $time);
        end else begin
          check("out_y", {31'd0, out_y}, {31'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_eval(in_x));
      prev_stall = out_valid && !out_ready;
      prev_y = out_y;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // All tasks below start and end on a falling edge.
  task automatic send(input logic [4:0] x);
    bit done;
    in_valid = 1'b1;
    in_x = x;
    done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      #4;
      if (in_ready) done = 1;
      @(negedge clk);
    end
    if (!done) timeout("send");
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input bit honoured, input bit sel, input int addr, input logic [15:0] data);
    int a;
    a = addr & 3;
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = 2'(a);
    cfg_wdata = data;
    if (honoured) begin
      if (!sel && a < K) mdl_m[a] = data[4:0];
      else if (sel && a < N_OUT) mdl_t[a] = data;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_ack(input int start, output int cnt);
    bit done;
    done = 0;
    cnt = start;
    for (int t = 0; t < 60 && !done; t++) begin
      #4;
      if (cfg_ack) done = 1;
      else begin
        if (cnt > 0) check("rdy_in_drain", {31'd0, in_ready}, 32'd0);
        cnt++;
      end
      @(negedge clk);
    end
    if (!done) timeout("wait_ack");
  endtask

  task automatic leave_cfg();
    cfg_req = 1'b0;
    #1;
    check("ack_drop", {31'd0, cfg_ack}, 32'd0);
    @(negedge clk);
    #4;
    check("rdy_after_cfg", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      #4;
      if (exp_q.size() == 0 && !out_valid && !dut.s1_v) done = 1;
      @(negedge clk);
    end
    if (!done) timeout("wait_idle");
  endtask

  initial begin
    int cnt;
    int acc;
    int xi;
    mdl_reset();
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset defaults and 2-cycle latency.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_x = 5'h0F;
    #4;
    check("rdy_after_rst", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    check("lat_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #4;
    check("lat_c2", {31'd0, out_valid}, 32'd1);
    @(negedge clk);

    // Write attempt outside the window must not land.
    cfg_write(0, 1, 0, 16'hFFFF);

    // Load M and T_0 from an empty pipeline.
    cfg_req = 1'b1;
    wait_ack(0, cnt);
    check("drain_empty_cycles", cnt, 32'd2);
    cfg_write(1, 0, 0, 16'h0003);
    cfg_write(1, 0, 1, 16'h0002);
    cfg_write(1, 0, 2, 16'h0004);
    cfg_write(1, 0, 3, 16'h0018);
    cfg_write(1, 1, 0, 16'h8000);
    cfg_write(1, 1, 7, 16'hFFFF);
    leave_cfg();
    send(5'h1D);
    send(5'h0E);
    for (int i = 0; i < 12; i++) send(5'($urandom));
    wait_idle();

    // Backpressure: only two samples fit while the sink stalls.
    out_ready = 1'b0;
    acc = 0;
    xi = 1;
    in_valid = 1'b1;
    in_x = 5'd1;
    repeat (6) begin
      #4;
      if (in_ready) begin acc++; xi++; end
      @(negedge clk);
      in_x = 5'(xi);
      if (xi > 3) in_valid = 1'b0;
    end
    check("bp_accepted", acc, 32'd2);
    #4;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int t = 0; t < 30 && xi <= 3; t++) begin
      #4;
      if (in_ready) xi++;
      @(negedge clk);
      in_x = 5'(xi);
      if (xi > 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    wait_idle();

    // Drain with two samples in flight; second arrives with the request.
    in_valid = 1'b1;
    in_x = 5'h0E;
    @(negedge clk);
    in_x = 5'h1D;
    cfg_req = 1'b1;
    #4;
    check("simul_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_ack(1, cnt);
    check("drain_busy_cycles", cnt, 32'd4);
    cfg_write(1, 1, 0, 16'h00F0);
    leave_cfg();

    // Request withdrawn during a drain that cannot finish.
    out_ready = 1'b0;
    send(5'h03);
    send(5'h07);
    cfg_req = 1'b1;
    repeat (3) begin
      #4;
      check("drop_no_ack", {31'd0, cfg_ack}, 32'd0);
      check("drop_rdy", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    cfg_req = 1'b0;
    wait_idle();
    #4;
    check("drop_rdy_back", {31'd0, in_ready}, 32'd1);
    check("drop_ack_low", {31'd0, cfg_ack}, 32'd0);
    @(negedge clk);

    // Randomized traffic with periodic random reconfiguration.
    for (int blk = 0; blk < 4; blk++) begin
      for (int c = 0; c < 60; c++) begin
        in_valid = 1'($urandom);
        in_x = 5'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      in_valid = 1'b0;
      wait_idle();
      cfg_req = 1'b1;
      wait_ack(0, cnt);
      for (int w = 0; w < 4; w++)
        cfg_write(1, 1'($urandom), $urandom_range(0, 3), 16'($urandom));
      leave_cfg();
    end

    // Mid-operation reset with a result waiting.
    out_ready = 1'b0;
    send(5'h0E);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_flush_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flush_ack", {31'd0, cfg_ack}, 32'd0);
    exp_q.delete();
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(5'($urandom));
    send(5'h0F);
    wait_idle();
    check("sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
